// File: rtl/decode_stage.sv
// MIPS-I decode stage: one registered output slot with valid/ready handshake,
// load-use interlock against the instruction in the slot, and a saturating stall counter.
module decode_stage #(
  parameter int PC_W   = 32,
  parameter int EXT_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [12:0]      out_op,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_dst,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUBU   = 6'h23;
  localparam logic [5:0] FN_SLT    = 6'h2A;

  localparam int B_ADDU  = 0;
  localparam int B_SUBU  = 1;
  localparam int B_ORI   = 2;
  localparam int B_LUI   = 3;
  localparam int B_LW    = 4;
  localparam int B_SW    = 5;
  localparam int B_BEQ   = 6;
  localparam int B_J     = 7;
  localparam int B_JAL   = 8;
  localparam int B_JR    = 9;
  localparam int B_ADDIU = 10;
  localparam int B_BNE   = 11;
  localparam int B_SLT   = 12;

  localparam logic             EXT     = (EXT_EN != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [5:0]  in_opc;
  logic [5:0]  in_fn;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;

  logic [12:0] dec_op;
  logic        dec_illegal;
  logic [4:0]  dec_dst;
  logic        dec_rs_read;
  logic        dec_rt_read;

  logic             hazard;
  logic             accept;

  logic             out_valid_q, out_valid_d;
  logic [12:0]      out_op_q, out_op_d;
  logic [4:0]       out_rs_q, out_rs_d;
  logic [4:0]       out_rt_q, out_rt_d;
  logic [4:0]       out_dst_q, out_dst_d;
  logic [PC_W-1:0]  out_pc_q, out_pc_d;
  logic             out_illegal_q, out_illegal_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign in_opc = in_instr[31:26];
  assign in_rs  = in_instr[25:21];
  assign in_rt  = in_instr[20:16];
  assign in_rd  = in_instr[15:11];
  assign in_fn  = in_instr[5:0];

  // Decoder: illegal encodings leave op, dst and read flags at zero so they never interlock.
  always_comb begin
    dec_op      = '0;
    dec_illegal = 1'b0;
    dec_dst     = '0;
    dec_rs_read = 1'b0;
    dec_rt_read = 1'b0;
    case (in_opc)
      OPC_RTYPE: begin
        if (in_instr != 32'h0) begin
          case (in_fn)
            FN_ADDU: begin
              dec_op[B_ADDU] = 1'b1;
              dec_dst        = in_rd;
              dec_rs_read    = 1'b1;
              dec_rt_read    = 1'b1;
            end
            FN_SUBU: begin
              dec_op[B_SUBU] = 1'b1;
              dec_dst        = in_rd;
              dec_rs_read    = 1'b1;
              dec_rt_read    = 1'b1;
            end
            FN_JR: begin
              dec_op[B_JR] = 1'b1;
              dec_rs_read  = 1'b1;
            end
            FN_SLT: begin
              if (EXT) begin
                dec_op[B_SLT] = 1'b1;
                dec_dst       = in_rd;
                dec_rs_read   = 1'b1;
                dec_rt_read   = 1'b1;
              end else begin
                dec_illegal = 1'b1;
              end
            end
            default: dec_illegal = 1'b1;
          endcase
        end
      end
      OPC_ORI: begin
        dec_op[B_ORI] = 1'b1;
        dec_dst       = in_rt;
        dec_rs_read   = 1'b1;
      end
      OPC_LUI: begin
        dec_op[B_LUI] = 1'b1;
        dec_dst       = in_rt;
      end
      OPC_LW: begin
        dec_op[B_LW] = 1'b1;
        dec_dst      = in_rt;
        dec_rs_read  = 1'b1;
      end
      OPC_SW: begin
        dec_op[B_SW] = 1'b1;
        dec_rs_read  = 1'b1;
        dec_rt_read  = 1'b1;
      end
      OPC_BEQ: begin
        dec_op[B_BEQ] = 1'b1;
        dec_rs_read   = 1'b1;
        dec_rt_read   = 1'b1;
      end
      OPC_J: begin
        dec_op[B_J] = 1'b1;
      end
      OPC_JAL: begin
        dec_op[B_JAL] = 1'b1;
        dec_dst       = 5'd31;
      end
      OPC_ADDIU: begin
        if (EXT) begin
          dec_op[B_ADDIU] = 1'b1;
          dec_dst         = in_rt;
          dec_rs_read     = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_BNE: begin
        if (EXT) begin
          dec_op[B_BNE] = 1'b1;
          dec_rs_read   = 1'b1;
          dec_rt_read   = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // A load sitting in the slot blocks any consumer of its destination until it has left.
  assign hazard = in_valid & out_valid_q & out_op_q[B_LW] & (out_dst_q != 5'd0) &
                  ((dec_rs_read & (in_rs == out_dst_q)) |
                   (dec_rt_read & (in_rt == out_dst_q)));

  assign in_ready = (~out_valid_q | out_ready) & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_op_d      = out_op_q;
    out_rs_d      = out_rs_q;
    out_rt_d      = out_rt_q;
    out_dst_d     = out_dst_q;
    out_pc_d      = out_pc_q;
    out_illegal_d = out_illegal_q;
    stall_cnt_d   = stall_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_op_d      = dec_op;
      out_rs_d      = in_rs;
      out_rt_d      = in_rt;
      out_dst_d     = dec_dst;
      out_pc_d      = in_pc;
      out_illegal_d = dec_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (hazard && !flush && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_op_q      <= '0;
      out_rs_q      <= '0;
      out_rt_q      <= '0;
      out_dst_q     <= '0;
      out_pc_q      <= '0;
      out_illegal_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_op_q      <= out_op_d;
      out_rs_q      <= out_rs_d;
      out_rt_q      <= out_rt_d;
      out_dst_q     <= out_dst_d;
      out_pc_q      <= out_pc_d;
      out_illegal_q <= out_illegal_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_op      = out_op_q;
  assign out_rs      = out_rs_q;
  assign out_rt      = out_rt_q;
  assign out_dst     = out_dst_q;
  assign out_pc      = out_pc_q;
  assign out_illegal = out_illegal_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a full-featured instance plus an EXT_EN=0 instance
// with a 2-bit stall counter, both driven by the same input stream.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_illegal;
  logic [12:0] out_op;
  logic [4:0]  out_rs, out_rt, out_dst;
  logic [31:0] out_pc;
  logic [15:0] stall_cnt;

  logic        nx_in_ready, nx_out_valid, nx_out_illegal;
  logic [12:0] nx_out_op;
  logic [4:0]  nx_out_rs, nx_out_rt, nx_out_dst;
  logic [31:0] nx_out_pc;
  logic [1:0]  nx_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  decode_stage #(.PC_W(32), .EXT_EN(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt),
    .out_dst(out_dst), .out_pc(out_pc), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  decode_stage #(.PC_W(32), .EXT_EN(0), .CNT_W(2)) u_noext (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nx_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(nx_out_valid),
    .out_ready(out_ready), .out_op(nx_out_op), .out_rs(nx_out_rs), .out_rt(nx_out_rt),
    .out_dst(nx_out_dst), .out_pc(nx_out_pc), .out_illegal(nx_out_illegal),
    .stall_cnt(nx_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkPayload(input string tag, input logic [12:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] dst,
                              input logic [31:0] pc, input logic ill);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, ".op"}, 32'(out_op), 32'(op));
    checkOutput({tag, ".rs"}, 32'(out_rs), 32'(rs));
    checkOutput({tag, ".rt"}, 32'(out_rt), 32'(rt));
    checkOutput({tag, ".dst"}, 32'(out_dst), 32'(dst));
    checkOutput({tag, ".pc"}, out_pc, pc);
    checkOutput({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, ".op"}, 32'(out_op), 32'd0);
    checkOutput({tag, ".regs"}, {17'd0, out_rs, out_rt, out_dst}, 32'd0);
    checkOutput({tag, ".pc"}, out_pc, 32'd0);
    checkOutput({tag, ".illegal"}, 32'(out_illegal), 32'd0);
    checkOutput({tag, ".stall"}, 32'(stall_cnt), 32'd0);
    checkOutput({tag, ".nx_stall"}, 32'(nx_stall_cnt), 32'd0);
  endtask

  initial begin
    // Power-up reset
    #1 rst_n = 1'b0;
    #2;
    checkResetState("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // addu $3,$1,$2
    applyStimulus(1'b1, 32'h00221821, 32'h100, 1'b1, 1'b0);
    checkOutput("addu.in_ready", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkPayload("addu", 13'h0001, 5'd1, 5'd2, 5'd3, 32'h100, 1'b0);
    tick();
    checkOutput("addu.drain", 32'(out_valid), 32'd0);

    // lw $0 then addu $6,$0,$0: no interlock on $0
    applyStimulus(1'b1, 32'h8C800000, 32'h110, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00003021, 32'h114, 1'b1, 1'b0);
    checkPayload("lw0", 13'h0010, 5'd4, 5'd0, 5'd0, 32'h110, 1'b0);
    checkOutput("lw0.in_ready", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkPayload("addu0", 13'h0001, 5'd0, 5'd0, 5'd6, 32'h114, 1'b0);
    checkOutput("lw0.stall", 32'(stall_cnt), 32'd0);
    tick();

    // lw $5,0($4) then addu $6,$5,$0: one bubble
    applyStimulus(1'b1, 32'h8C850000, 32'h120, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00A03021, 32'h124, 1'b1, 1'b0);
    checkPayload("lw5", 13'h0010, 5'd4, 5'd5, 5'd5, 32'h120, 1'b0);
    checkOutput("lu.in_ready_hazard", 32'(in_ready), 32'd0);
    tick();
    checkOutput("lu.bubble_valid", 32'(out_valid), 32'd0);
    checkOutput("lu.stall", 32'(stall_cnt), 32'd1);
    checkOutput("lu.in_ready_bubble", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkPayload("lu.consumer", 13'h0001, 5'd5, 5'd0, 5'd6, 32'h124, 1'b0);
    checkOutput("lu.stall_after", 32'(stall_cnt), 32'd1);
    tick();

    // ori held by out_ready=0 for three cycles, sw waiting behind it
    applyStimulus(1'b1, 32'h34271234, 32'h200, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hAC620004, 32'h204, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkPayload("hold.ori", 13'h0004, 5'd1, 5'd7, 5'd7, 32'h200, 1'b0);
      checkOutput("hold.in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    checkPayload("hold.ori_last", 13'h0004, 5'd1, 5'd7, 5'd7, 32'h200, 1'b0);
    applyStimulus(1'b1, 32'hAC620004, 32'h204, 1'b1, 1'b0);
    checkOutput("hold.release_ready", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkPayload("hold.sw", 13'h0020, 5'd3, 5'd2, 5'd0, 32'h204, 1'b0);
    tick();
    checkOutput("hold.no_dup", 32'(out_valid), 32'd0);

    // slt on both instances
    applyStimulus(1'b1, 32'h0022182A, 32'h300, 1'b1, 1'b0);
    tick();
    checkPayload("slt.ext", 13'h1000, 5'd1, 5'd2, 5'd3, 32'h300, 1'b0);
    checkOutput("slt.noext_valid", 32'(nx_out_valid), 32'd1);
    checkOutput("slt.noext_op", 32'(nx_out_op), 32'd0);
    checkOutput("slt.noext_illegal", 32'(nx_out_illegal), 32'd1);

    // Back-to-back stream: jal, illegal opcode, nop
    applyStimulus(1'b1, 32'h0C000010, 32'h304, 1'b1, 1'b0);
    tick();
    checkPayload("jal", 13'h0100, 5'd0, 5'd0, 5'd31, 32'h304, 1'b0);
    applyStimulus(1'b1, 32'hFC000000, 32'h308, 1'b1, 1'b0);
    tick();
    checkPayload("illegal", 13'h0000, 5'd0, 5'd0, 5'd0, 32'h308, 1'b1);
    applyStimulus(1'b1, 32'h00000000, 32'h30C, 1'b1, 1'b0);
    tick();
    checkPayload("nop", 13'h0000, 5'd0, 5'd0, 5'd0, 32'h30C, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();

    // Load-use stall held by out_ready=0: counters grow, 2-bit one saturates
    applyStimulus(1'b1, 32'h8C850000, 32'h400, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00A03021, 32'h404, 1'b0, 1'b0);
    repeat (4) tick();
    checkOutput("sat.stall", 32'(stall_cnt), 32'd5);
    checkOutput("sat.nx_stall", 32'(nx_stall_cnt), 32'd3);
    checkOutput("sat.held_valid", 32'(out_valid), 32'd1);

    // Flush together with in_valid while the hazard is still present
    applyStimulus(1'b1, 32'h00A03021, 32'h404, 1'b0, 1'b1);
    checkOutput("flush.in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("flush.valid", 32'(out_valid), 32'd0);
    checkOutput("flush.stall", 32'(stall_cnt), 32'd5);
    applyStimulus(1'b1, 32'h00A03021, 32'h404, 1'b1, 1'b0);
    checkOutput("flush.after_ready", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkPayload("flush.next", 13'h0001, 5'd5, 5'd0, 5'd6, 32'h404, 1'b0);
    tick();

    // Reset pulsed mid-stream
    applyStimulus(1'b1, 32'h3C09ABCD, 32'h500, 1'b1, 1'b0);
    tick();
    checkPayload("rst.lui", 13'h0008, 5'd0, 5'd9, 5'd9, 32'h500, 1'b0);
    applyStimulus(1'b1, 32'h34271234, 32'h504, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkResetState("rst.async");
    tick();
    checkOutput("rst.held_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst.release_valid", 32'(out_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkPayload("rst.first", 13'h0004, 5'd1, 5'd7, 5'd7, 32'h504, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
